// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit registered ALU and the sequencer that
// drives it:
//   - 3-bit opcode encodings (add..shl)
//   - bit positions of the ALU flags vector, ordered {C,N,O,Z}
//   - state encoding of the sequencer FSM
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALU opcodes
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_NOT  = 3'd4;
  localparam logic [2:0] OP_COMP = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  // Bit indices within the 4-bit flags vector
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/regbank_8x8.sv
// ---------------------------------------------------------------------------
// regbank_8x8
// Eight 8-bit registers with one synchronous write port and three
// combinational read ports (two operand reads, one debug read).
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset (clears all)
//   i_we, i_waddr, i_wdata  write port
//   i_raddr_a / o_rdata_a   operand A read
//   i_raddr_b / o_rdata_b   operand B read
//   i_raddr_d / o_rdata_d   debug read
// ---------------------------------------------------------------------------
module regbank_8x8 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [2:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [2:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [2:0] i_raddr_b,
  output logic [7:0] o_rdata_b,
  input  logic [2:0] i_raddr_d,
  output logic [7:0] o_rdata_d
);
  import alu_pkg::*;

  logic [7:0] r_mem [0:7];

  // Register array: cleared on reset, single write port otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rdata_d = r_mem[i_raddr_d];

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Issue/capture controller in front of an external 8-bit registered ALU.
// Accepts one instruction per valid/ready handshake, reads operands from the
// internal register bank, drives the ALU for one ISSUE cycle, then in CAPTURE
// samples the ALU result/flags, optionally writes the result back and pulses
// done in the following cycle.
// Ports:
//   clk, rst                         clock, async active-high reset
//   instr_valid / instr_ready        instruction handshake
//   instr_op/dst/src/imm_en/imm/wb   instruction fields
//   alu_a, alu_b, alu_op             registered ALU drives
//   alu_out, alu_flags               ALU result (registered in ALU) and flags
//   flags_q                          flags of the last completed instruction
//   done                             one-cycle completion pulse
//   dbg_addr / dbg_data              combinational debug register read
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int NREGS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_op,
  input  logic [2:0] instr_dst,
  input  logic [2:0] instr_src,
  input  logic       instr_imm_en,
  input  logic [7:0] instr_imm,
  input  logic       instr_wb,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags_q,
  output logic       done,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);
  import alu_pkg::*;

  localparam int AW = $clog2(NREGS);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [7:0]    r_alu_a;
  logic [7:0]    r_alu_b;
  logic [2:0]    r_alu_op;
  logic [AW-1:0] r_dst;
  logic          r_wb;
  logic [3:0]    r_flags;
  logic          r_done;

  logic          w_handshake;
  logic          w_capture;
  logic [7:0]    w_rd_a;
  logic [7:0]    w_rd_b;

  assign instr_ready = (r_state == ST_IDLE);
  assign w_handshake = instr_valid & instr_ready;
  assign w_capture   = (r_state == ST_CAPTURE);

  // Operand reads are addressed straight from the instruction bus because the
  // drives are registered on the handshake edge; this also lets an instruction
  // accepted in a done cycle see the write-back of its predecessor.
  regbank_8x8 u_regbank (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (w_capture & r_wb),
    .i_waddr   (r_dst),
    .i_wdata   (alu_out),
    .i_raddr_a (instr_dst),
    .o_rdata_a (w_rd_a),
    .i_raddr_b (instr_src),
    .o_rdata_b (w_rd_b),
    .i_raddr_d (dbg_addr),
    .o_rdata_d (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (instr_valid) begin
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE:   w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // ALU drives and latched instruction fields; loaded only on a handshake so
  // they stay frozen through ISSUE and CAPTURE (the ALU flags depend on them)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a  <= 8'h00;
      r_alu_b  <= 8'h00;
      r_alu_op <= 3'd0;
      r_dst    <= '0;
      r_wb     <= 1'b0;
    end else if (w_handshake) begin
      r_alu_a  <= w_rd_a;
      r_alu_b  <= instr_imm_en ? instr_imm : w_rd_b;
      r_alu_op <= instr_op;
      r_dst    <= instr_dst[AW-1:0];
      r_wb     <= instr_wb;
    end
  end

  // Capture of flags and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 4'b0000;
      r_done  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_flags <= alu_flags;
      end
      r_done <= w_capture;
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_op  = r_alu_op;
  assign flags_q = r_flags;
  assign done    = r_done;

endmodule
